shift_reg_param: RTL

SHIFT_REG_PARAM -- requirements
Module: shift_reg_param

---
 rtl/shift_reg_param_if.sv | 52 +++++
 rtl/shift_reg_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_param_if.sv
// ---------------------------------------------------------------------------
// shift_reg_param_if
// Bundles the control and data signals of shift_reg_param.
//
// Parameters
//   WIDTH      register width in bits
//   AMT_W      shift-amount width, $clog2(WIDTH)
//
// Signals
//   enable     global advance qualifier; low freezes the block
//   start      operation request
//   mode       operation select (hold/load/SLL/SRL/SRA/ROL/ROR/clear)
//   amount     shift or rotate distance
//   data_in    parallel load value
//   serial_in  fill bit for SLL/SRL
//   data_out   register contents
//   serial_out last bit shifted or rotated out
//   busy       high while a multi-cycle shift is running
//   done       one-cycle completion pulse
//
// Modports
//   master     drives the requests (testbench or host logic)
//   slave      the shift register itself
//
// The instance parameters must match those of the shift_reg_param that
// uses the slave modport.
// ---------------------------------------------------------------------------
interface shift_reg_param_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             enable;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output enable, start, mode, amount, data_in, serial_in,
        input  data_out, serial_out, busy, done
    );

    modport slave (
        input  enable, start, mode, amount, data_in, serial_in,
        output data_out, serial_out, busy, done
    );
endinterface

// File: rtl/shift_reg_param.sv
// ---------------------------------------------------------------------------
// shift_reg_param
// Parameterised shift/rotate register with a small request/done handshake.
// Modes: 000 hold, 001 load, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR,
// 111 clear.
//
// Ports
//   clk    single clock, all state changes on its rising edge
//   reset  synchronous, active-high reset (beats enable and every request)
//   bus    shift_reg_param_if.slave: enable, start, mode, amount, data_in,
//          serial_in in; data_out, serial_out, busy, done out
//
// Build option
//   SHIFT_REG_PARAM_BARREL_EN  when defined, shifts and rotates finish at
//          the accept edge through a barrel network and SHIFT is never
//          entered. When undefined (default), a shift moves one bit per
//          enabled cycle. Final data_out/serial_out match in both builds.
// ---------------------------------------------------------------------------
module shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_reg_param_if.slave      bus
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SLL   = 3'b010;
    localparam logic [2:0] MODE_SRL   = 3'b011;
    localparam logic [2:0] MODE_SRA   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ROR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             fill_q;
    logic [AMT_W-1:0] count_q;
    logic [WIDTH-1:0] data_q;
    logic             serial_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] step_data;
    logic             step_out;

    // One-bit move of the register in the captured direction, used while in
    // SHIFT. The exiting bit is returned alongside so serial_out can follow.
    always_comb begin
        step_data = data_q;
        step_out  = serial_q;
        case (op_q)
            MODE_SLL: begin
                step_data = {data_q[WIDTH-2:0], fill_q};
                step_out  = data_q[WIDTH-1];
            end
            MODE_SRL: begin
                step_data = {fill_q, data_q[WIDTH-1:1]};
                step_out  = data_q[0];
            end
            MODE_SRA: begin
                step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_out  = data_q[0];
            end
            MODE_ROL: begin
                step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_out  = data_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_data = {data_q[0], data_q[WIDTH-1:1]};
                step_out  = data_q[0];
            end
            default: begin
                step_data = data_q;
                step_out  = serial_q;
            end
        endcase
    end

`ifdef SHIFT_REG_PARAM_BARREL_EN
    logic [WIDTH-1:0] barrel_data;
    logic             barrel_serial;
    logic [AMT_W-1:0] rot_amt;
    logic [WIDTH:0]   sll_res;
    logic [WIDTH:0]   srl_res;
    logic [WIDTH:0]   sra_res;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] ror_res;

    // Full-distance shift/rotate computed from the live request inputs at the
    // accept edge. Shifts run through a 3*WIDTH extension padded with two
    // words of fill (or sign) so amounts up to 2*WIDTH-1 still produce the
    // correct fill pattern; the extra bit beyond the result catches the last
    // bit that fell out. For rotates the last exiting bit is the one that
    // wrapped into the vacated end of the result.
    always_comb begin
        rot_amt = AMT_W'(32'(bus.amount) % WIDTH);
        sll_res = (WIDTH+1)'(({1'b0, data_q, {2*WIDTH{bus.serial_in}}}
                              << bus.amount) >> (2*WIDTH));
        srl_res = (WIDTH+1)'({{2*WIDTH{bus.serial_in}}, data_q, 1'b0}
                             >> bus.amount);
        sra_res = (WIDTH+1)'({{2*WIDTH{data_q[WIDTH-1]}}, data_q, 1'b0}
                             >> bus.amount);
        rol_res = WIDTH'(({data_q, data_q} << rot_amt) >> WIDTH);
        ror_res = WIDTH'({data_q, data_q} >> rot_amt);

        barrel_data   = data_q;
        barrel_serial = serial_q;
        case (bus.mode)
            MODE_SLL: begin
                barrel_data   = sll_res[WIDTH-1:0];
                barrel_serial = sll_res[WIDTH];
            end
            MODE_SRL: begin
                barrel_data   = srl_res[WIDTH:1];
                barrel_serial = srl_res[0];
            end
            MODE_SRA: begin
                barrel_data   = sra_res[WIDTH:1];
                barrel_serial = sra_res[0];
            end
            MODE_ROL: begin
                barrel_data   = rol_res;
                barrel_serial = rol_res[0];
            end
            MODE_ROR: begin
                barrel_data   = ror_res;
                barrel_serial = ror_res[WIDTH-1];
            end
            default: begin
                barrel_data   = data_q;
                barrel_serial = serial_q;
            end
        endcase
    end
`endif

    // Control FSM with registered busy/done. Nothing advances while enable is
    // low, so every register (including busy and done) simply holds. Hold,
    // load, clear and zero-distance shifts finish at the accept edge; longer
    // shifts either iterate in SHIFT or finish via the barrel network.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= MODE_HOLD;
            fill_q   <= 1'b0;
            count_q  <= '0;
            data_q   <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.enable) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.mode;
                        fill_q <= bus.serial_in;
                        state  <= DONE;
                        done_q <= 1'b1;
                        case (bus.mode)
                            MODE_HOLD: begin
                                data_q <= data_q;
                            end
                            MODE_LOAD: begin
                                data_q <= bus.data_in;
                            end
                            MODE_CLEAR: begin
                                data_q <= '0;
                            end
                            default: begin
                                if (bus.amount != '0) begin
`ifdef SHIFT_REG_PARAM_BARREL_EN
                                    data_q   <= barrel_data;
                                    serial_q <= barrel_serial;
`else
                                    count_q <= bus.amount;
                                    state   <= SHIFT;
                                    busy_q  <= 1'b1;
                                    done_q  <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    data_q   <= step_data;
                    serial_q <= step_out;
                    count_q  <= count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.serial_out = serial_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
